// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU, with a one-deep response register per port.
// Build option: define ALU_ARB_FIXED_PRIO_EN for strict port-0 priority instead of round-robin.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_alu_sel,
    input  logic [2:0]        req0_b_sel,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_take_branch,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_alu_sel,
    input  logic [2:0]        req1_b_sel,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_take_branch,

    output logic [DATA_W-1:0] alu_a1,
    output logic [DATA_W-1:0] alu_scr2,
    output logic [3:0]        alu_sel,
    output logic [2:0]        alu_b_sel,
    input  logic [DATA_W-1:0] alu_rslt,
    input  logic              alu_take_branch
);

    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_result;
    logic              r_rsp0_take_branch;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_result;
    logic              r_rsp1_take_branch;

    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;

    // A port may be granted while its response slot is draining this cycle.
    assign w_elig0 = req0_valid & (~r_rsp0_valid | rsp0_ready);
    assign w_elig1 = req1_valid & (~r_rsp1_valid | rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            w_gnt0 = w_elig0;
            w_gnt1 = w_elig1 & ~w_elig0;
        end
    end
`else
    logic r_last_grant;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n) begin
            if (w_elig0 & w_elig1) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else begin
                w_gnt0 = w_elig0;
                w_gnt1 = w_elig1;
            end
        end
    end

    // Reset value 1 makes the first tie after reset go to port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_last_grant <= w_gnt1;
        end
    end
`endif

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_a1    = '0;
        alu_scr2  = '0;
        alu_sel   = 4'b0000;
        alu_b_sel = 3'b111;
        if (w_gnt0) begin
            alu_a1    = req0_a;
            alu_scr2  = req0_b;
            alu_sel   = req0_alu_sel;
            alu_b_sel = req0_b_sel;
        end else if (w_gnt1) begin
            alu_a1    = req1_a;
            alu_scr2  = req1_b;
            alu_sel   = req1_alu_sel;
            alu_b_sel = req1_b_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid       <= 1'b0;
            r_rsp0_result      <= '0;
            r_rsp0_take_branch <= 1'b0;
        end else if (w_gnt0) begin
            r_rsp0_valid       <= 1'b1;
            r_rsp0_result      <= alu_rslt;
            r_rsp0_take_branch <= alu_take_branch;
        end else if (rsp0_ready) begin
            r_rsp0_valid       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp1_valid       <= 1'b0;
            r_rsp1_result      <= '0;
            r_rsp1_take_branch <= 1'b0;
        end else if (w_gnt1) begin
            r_rsp1_valid       <= 1'b1;
            r_rsp1_result      <= alu_rslt;
            r_rsp1_take_branch <= alu_take_branch;
        end else if (rsp1_ready) begin
            r_rsp1_valid       <= 1'b0;
        end
    end

    assign rsp0_valid       = r_rsp0_valid;
    assign rsp0_result      = r_rsp0_result;
    assign rsp0_take_branch = r_rsp0_take_branch;
    assign rsp1_valid       = r_rsp1_valid;
    assign rsp1_result      = r_rsp1_result;
    assign rsp1_take_branch = r_rsp1_take_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter; a behavioural ALU stands in for the real one.
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v[2];
    logic        rr[2];
    logic [31:0] a[2];
    logic [31:0] b[2];
    logic [3:0]  sel[2];
    logic [2:0]  bs[2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_take_branch, rsp1_take_branch;
    logic [31:0] alu_a1, alu_scr2, alu_rslt;
    logic [3:0]  alu_sel;
    logic [2:0]  alu_b_sel;
    logic        alu_take_branch;

    // reference model state: what each response slot should hold, and who was served last
    logic        m_valid[2];
    logic [31:0] m_res[2];
    logic        m_tb[2];
    int          m_last;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x << y[4:0];
            4'd3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd4: return (x < y) ? 32'd1 : 32'd0;
            4'd5: return x ^ y;
            4'd6: return x >> y[4:0];
            4'd7: return 32'($signed(x) >>> y[4:0]);
            4'd8: return x | y;
            4'd9: return x & y;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_br(input logic [31:0] x, input logic [31:0] y, input logic [2:0] c);
        case (c)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return $signed(x) < $signed(y);
            3'd3: return $signed(x) >= $signed(y);
            3'd4: return x < y;
            3'd5: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    assign alu_rslt        = ref_alu(alu_a1, alu_scr2, alu_sel);
    assign alu_take_branch = ref_br(alu_a1, alu_scr2, alu_b_sel);

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_a(a[0]), .req0_b(b[0]),
        .req0_alu_sel(sel[0]), .req0_b_sel(bs[0]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_result(rsp0_result),
        .rsp0_take_branch(rsp0_take_branch),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_a(a[1]), .req1_b(b[1]),
        .req1_alu_sel(sel[1]), .req1_b_sel(bs[1]),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_result(rsp1_result),
        .rsp1_take_branch(rsp1_take_branch),
        .alu_a1(alu_a1), .alu_scr2(alu_scr2), .alu_sel(alu_sel), .alu_b_sel(alu_b_sel),
        .alu_rslt(alu_rslt), .alu_take_branch(alu_take_branch)
    );

    // Expected grant vector {port1, port0}: serve the eligible port, on a tie the one not served last.
    function automatic logic [1:0] exp_gnt();
        bit e0, e1;
        if (!rst_n) return 2'b00;
        e0 = v[0] && (!m_valid[0] || rr[0]);
        e1 = v[1] && (!m_valid[1] || rr[1]);
        if (e0 && e1) return FIXED ? 2'b01 : ((m_last == 0) ? 2'b10 : 2'b01);
        return {e1, e0};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0;
            m_res[p]   = 32'd0;
            m_tb[p]    = 1'b0;
        end
        m_last = 1;
    endtask

    task automatic set_port(input int p, input logic vv, input logic [31:0] aa, input logic [31:0] bb,
                            input logic [3:0] ss, input logic [2:0] cc, input logic rdy);
        v[p] = vv; a[p] = aa; b[p] = bb; sel[p] = ss; bs[p] = cc; rr[p] = rdy;
    endtask

    // Moves the model and the DUT across one rising edge; leaves time at edge+1.
    task automatic advance();
        logic [1:0]  g;
        logic [31:0] nr[2];
        logic        nt[2];
        g = exp_gnt();
        for (int p = 0; p < 2; p++) begin
            nr[p] = ref_alu(a[p], b[p], sel[p]);
            nt[p] = ref_br(a[p], b[p], bs[p]);
        end
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                m_valid[p] = 1'b1; m_res[p] = nr[p]; m_tb[p] = nt[p];
            end else if (rr[p]) begin
                m_valid[p] = 1'b0;
            end
        end
        if (g != 2'b00 && !FIXED) m_last = g[1] ? 1 : 0;
        #1;
    endtask

    task automatic do_reset();
        set_port(0, 0, 0, 0, 0, 3'b111, 1);
        set_port(1, 0, 0, 0, 0, 3'b111, 1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        set_port(0, 1, 32'd1, 32'd2, 4'd0, 3'b000, 1);
        set_port(1, 1, 32'd3, 32'd4, 4'd0, 3'b000, 1);
        #2;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready});
        end
        n_vec++;
        if ({rsp1_valid, rsp0_valid, rsp1_take_branch, rsp0_take_branch} !== 4'b0000) begin
            n_err++; $display("FAIL reset_rsp_flags got %b want 0000",
                              {rsp1_valid, rsp0_valid, rsp1_take_branch, rsp0_take_branch});
        end
        n_vec++;
        if ({rsp1_result, rsp0_result} !== 64'd0) begin
            n_err++; $display("FAIL reset_result got %h want 0", {rsp1_result, rsp0_result});
        end
        n_vec++;
        if (alu_b_sel !== 3'b111 || alu_a1 !== 32'd0) begin
            n_err++; $display("FAIL reset_alu_idle got bsel=%b a1=%h want 111/0", alu_b_sel, alu_a1);
        end
        do_reset();
    endtask

    task automatic test_single_add();
        set_port(0, 1, 32'd5, 32'd7, 4'd0, 3'b110, 1);
        @(negedge clk);
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL add_grant got %b want 01", {req1_ready, req0_ready});
        end
        advance();
        set_port(0, 0, 0, 0, 0, 3'b111, 1);
        @(negedge clk);
        n_vec++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12) begin
            n_err++; $display("FAIL add_result got v=%b r=%0d want v=1 r=12", rsp0_valid, rsp0_result);
        end
        advance();
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1, 32'd10, 32'd3, 4'd1, 3'b110, 1);
            set_port(1, 1, 32'hFFFF_FFFF, 32'd1, 4'd3, 3'b110, 1);
            @(negedge clk);
            want = FIXED ? 2'b01 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            n_vec++;
            if ({req1_ready, req0_ready} !== want) begin
                n_err++; $display("FAIL alt_grant cycle %0d got %b want %b", i, {req1_ready, req0_ready}, want);
            end
            n_vec++;
            if ({rsp1_result, rsp0_result} !== {m_res[1], m_res[0]}) begin
                n_err++; $display("FAIL alt_result cycle %0d got %h want %h", i,
                                  {rsp1_result, rsp0_result}, {m_res[1], m_res[0]});
            end
            advance();
        end
        n_vec++;
        if (rsp0_result !== 32'd7 || rsp1_result !== (FIXED ? 32'd0 : 32'd1)) begin
            n_err++; $display("FAIL alt_final got %0d/%0d want 7/%0d", rsp0_result, rsp1_result, FIXED ? 0 : 1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_port(1, 1, 32'hFFFF_FFFE, 32'd3, 4'd0, 3'b010, 0);
        @(negedge clk);
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_err++; $display("FAIL bp_first got %b want 10", {req1_ready, req0_ready});
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1, $urandom, $urandom, 4'($urandom_range(0, 9)), 3'b110, 1);
            @(negedge clk);
            n_vec++;
            if ({req1_ready, req0_ready} !== 2'b01) begin
                n_err++; $display("FAIL bp_hold_grant cycle %0d got %b want 01", i, {req1_ready, req0_ready});
            end
            n_vec++;
            if (rsp1_valid !== 1'b1 || rsp1_take_branch !== 1'b1 || rsp1_result !== 32'd1) begin
                n_err++; $display("FAIL bp_hold_rsp cycle %0d got v=%b tb=%b r=%h want 1/1/1", i,
                                  rsp1_valid, rsp1_take_branch, rsp1_result);
            end
            n_vec++;
            if (rsp0_result !== m_res[0]) begin
                n_err++; $display("FAIL bp_port0 cycle %0d got %h want %h", i, rsp0_result, m_res[0]);
            end
            advance();
        end
        rr[1] = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({req1_ready, req0_ready} !== (FIXED ? 2'b01 : 2'b10)) begin
            n_err++; $display("FAIL bp_release got %b want %b", {req1_ready, req0_ready}, FIXED ? 2'b01 : 2'b10);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops[3];
        logic [31:0] exp_q[$];
        ops[0] = 4'd5; ops[1] = 4'd8; ops[2] = 4'd9;
        set_port(1, 0, 0, 0, 0, 3'b111, 1);
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) begin
                set_port(0, 1, 32'hF0F0_00FF + 32'(i), 32'h0FF0_F00F, ops[i], 3'b110, 1);
                exp_q.push_back(ref_alu(a[0], b[0], ops[i]));
            end else begin
                set_port(0, 0, 0, 0, 0, 3'b111, 1);
            end
            @(negedge clk);
            if (i >= 1) begin
                n_vec++;
                if (rsp0_valid !== 1'b1 || rsp0_result !== exp_q[i-1]) begin
                    n_err++; $display("FAIL b2b_result %0d got v=%b r=%h want v=1 r=%h", i,
                                      rsp0_valid, rsp0_result, exp_q[i-1]);
                end
            end
            if (i < 3) begin
                n_vec++;
                if (req0_ready !== 1'b1) begin
                    n_err++; $display("FAIL b2b_ready %0d got %b want 1", i, req0_ready);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(0, 1, 32'd1, 32'd2, 4'd0, 3'b110, 0);
        advance();
        #2;
        n_vec++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd3) begin
            n_err++; $display("FAIL mid_pre got v=%b r=%h want 1/3", rsp0_valid, rsp0_result);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00 || rsp0_result !== 32'd0) begin
            n_err++; $display("FAIL mid_async got v=%b r=%h want 00/0", {rsp1_valid, rsp0_valid}, rsp0_result);
        end
        set_port(0, 1, 32'd4, 32'd4, 4'd0, 3'b000, 1);
        set_port(1, 1, 32'd9, 32'd9, 4'd0, 3'b000, 1);
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_err++; $display("FAIL mid_ready_in_reset got %b want 00", {req1_ready, req0_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL mid_first_tie got %b want 01", {req1_ready, req0_ready});
        end
        advance();
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic [31:0] ea;
        logic [2:0]  eb;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                set_port(p, 1'($urandom), ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
                         ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom,
                         4'($urandom_range(0, 9)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
            end
            @(negedge clk);
            g  = exp_gnt();
            ea = g[0] ? a[0] : (g[1] ? a[1] : 32'd0);
            eb = g[0] ? bs[0] : (g[1] ? bs[1] : 3'b111);
            n_vec++;
            if ({req1_ready, req0_ready} !== g) begin
                n_err++; $display("FAIL rnd_grant cycle %0d got %b want %b", i, {req1_ready, req0_ready}, g);
            end
            n_vec++;
            if (alu_a1 !== ea || alu_b_sel !== eb) begin
                n_err++; $display("FAIL rnd_alu_drive cycle %0d got %h/%b want %h/%b", i, alu_a1, alu_b_sel, ea, eb);
            end
            n_vec++;
            if ({rsp1_valid, rsp0_valid, rsp1_take_branch, rsp0_take_branch} !==
                {m_valid[1], m_valid[0], m_tb[1], m_tb[0]}) begin
                n_err++; $display("FAIL rnd_rsp_flags cycle %0d got %b want %b", i,
                                  {rsp1_valid, rsp0_valid, rsp1_take_branch, rsp0_take_branch},
                                  {m_valid[1], m_valid[0], m_tb[1], m_tb[0]});
            end
            n_vec++;
            if ({rsp1_result, rsp0_result} !== {m_res[1], m_res[0]}) begin
                n_err++; $display("FAIL rnd_result cycle %0d got %h want %h", i,
                                  {rsp1_result, rsp0_result}, {m_res[1], m_res[0]});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
